// File: rtl/audio_pkg.sv
// Shared audio definitions for the codec link (ADC capture and DAC playback sides).
// Sample widths, FIFO depth, channel encoding and the left/right sample-pair record.
`timescale 1ns/1ps
package audio_pkg;

  localparam int AUDIO_SAMPLE_W   = 24;
  localparam int AUDIO_OUT_W      = 32;
  localparam int AUDIO_FIFO_DEPTH = 8;
  localparam int AUDIO_PEAK_W     = 7;
  localparam int PEAK_DECAY_LOG2  = 20;

  // LRCK level encodes the channel currently being shifted.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] left;
    logic [AUDIO_SAMPLE_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/i2s_adc_receiver_if.sv
// User-side bus of the ADC receiver: read/flush controls, head-of-FIFO samples and status.
// With ADC_PEAK_EN defined the bus also carries the peak_level meter.
`timescale 1ns/1ps
interface i2s_adc_receiver_if #(
  parameter int OUT_W = audio_pkg::AUDIO_OUT_W
);
  logic                                clear_audio_in_memory;
  logic                                read_audio_in;
  logic [OUT_W-1:0]                    left_channel_audio_in;
  logic [OUT_W-1:0]                    right_channel_audio_in;
  logic                                audio_in_available;
  logic                                overflow;
`ifdef ADC_PEAK_EN
  logic [audio_pkg::AUDIO_PEAK_W-1:0]  peak_level;
`endif

  modport master (
    output clear_audio_in_memory, read_audio_in,
`ifdef ADC_PEAK_EN
    input  peak_level,
`endif
    input  left_channel_audio_in, right_channel_audio_in, audio_in_available, overflow
  );

  modport slave (
    input  clear_audio_in_memory, read_audio_in,
`ifdef ADC_PEAK_EN
    output peak_level,
`endif
    output left_channel_audio_in, right_channel_audio_in, audio_in_available, overflow
  );
endinterface

// File: rtl/audio_rx_fifo.sv
// Synchronous first-word-fall-through FIFO of packed sample pairs.
// Clear wins over push/pop; pop on empty and push on full (without pop) are ignored.
`timescale 1ns/1ps
module audio_rx_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  // NOTE: storage has no reset; the count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// WM8731 ADC I2S capture (codec is BCLK/LRCK master): synchronizers, deserializer, pair FIFO.
// Optional feature macro ADC_PEAK_EN adds a decaying peak |sample| meter on the user bus.
`timescale 1ns/1ps
module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int DATA_W     = AUDIO_SAMPLE_W,
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH,
  parameter int OUT_W      = AUDIO_OUT_W
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  AUD_ADCDAT,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  i2s_adc_receiver_if.slave     bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PW    = 2 * DATA_W;

  logic [1:0] bclk_sync, lrck_sync, dat_sync;
  logic       bclk_prev, bclk_rise;
  chan_t      lrck_s, lrck_prev;

  // NOTE: non-blocking assignments make each stage take the previous stage's old value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[0],  AUD_ADCDAT};
      bclk_prev <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lrck_s    = chan_t'(lrck_sync[1]);

  logic [DATA_W-1:0] shift_reg, left_word;
  logic [CNT_W-1:0]  bitcnt;
  logic              left_ok, synced, boundary, word_full, push_req;

  assign boundary  = bclk_rise & (lrck_s != lrck_prev);
  assign word_full = (bitcnt == CNT_W'(DATA_W));
  // A pair is only complete on the R->L boundary, and only once a full frame was seen.
  assign push_req  = boundary & (lrck_s == CH_LEFT) & synced & left_ok & word_full;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_reg <= '0;
      left_word <= '0;
      bitcnt    <= '0;
      left_ok   <= 1'b0;
      synced    <= 1'b0;
      lrck_prev <= CH_RIGHT;
    end else if (bclk_rise) begin
      if (lrck_s != lrck_prev) begin
        bitcnt    <= '0;
        lrck_prev <= lrck_s;
        if (lrck_s == CH_RIGHT) begin
          left_word <= shift_reg;
          left_ok   <= word_full;
        end else begin
          synced    <= 1'b1;
        end
      end else if (bitcnt < CNT_W'(DATA_W)) begin
        shift_reg <= {shift_reg[DATA_W-2:0], dat_sync[1]};
        bitcnt    <= bitcnt + CNT_W'(1);
      end
    end
  end

  logic [PW-1:0]               head_pair, held_pair, shown_pair;
  logic                        fifo_full, fifo_empty, pop_ok, drop, overflow_q;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  audio_rx_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (resetn),
    .clear   (bus.clear_audio_in_memory),
    .push    (push_req),
    .pop     (bus.read_audio_in),
    .wr_data ({left_word, shift_reg}),
    .rd_data (head_pair),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop_ok = bus.read_audio_in & (fifo_count != '0);
  assign drop   = push_req & fifo_full & ~pop_ok;

  // The outputs keep showing the last head after the FIFO drains or is flushed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_pair  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (!fifo_empty) held_pair <= head_pair;
      if (bus.clear_audio_in_memory) overflow_q <= 1'b0;
      else if (drop)                 overflow_q <= 1'b1;
    end
  end

  assign shown_pair = fifo_empty ? held_pair : head_pair;

  assign bus.left_channel_audio_in  = {{(OUT_W-DATA_W){shown_pair[PW-1]}},     shown_pair[PW-1:DATA_W]};
  assign bus.right_channel_audio_in = {{(OUT_W-DATA_W){shown_pair[DATA_W-1]}}, shown_pair[DATA_W-1:0]};
  assign bus.audio_in_available     = ~fifo_empty;
  assign bus.overflow               = overflow_q;

`ifdef ADC_PEAK_EN
  // Magnitude with the most negative code saturated, reduced to its top meter bits.
  function automatic logic [AUDIO_PEAK_W-1:0] peak_bits(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] mag;
    if (w == {1'b1, {(DATA_W-1){1'b0}}}) mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w[DATA_W-1])                mag = -w;
    else                                 mag = w;
    return mag[DATA_W-2 -: AUDIO_PEAK_W];
  endfunction

  logic [AUDIO_PEAK_W-1:0]    peak_q, pk_l, pk_r, pk_pair, pk_new;
  logic [PEAK_DECAY_LOG2-1:0] decay_cnt;
  logic                       push_ok;

  assign push_ok = push_req & (~fifo_full | pop_ok) & ~bus.clear_audio_in_memory;
  assign pk_l    = peak_bits(left_word);
  assign pk_r    = peak_bits(shift_reg);
  assign pk_pair = (pk_l > pk_r) ? pk_l : pk_r;
  assign pk_new  = (pk_pair > peak_q) ? pk_pair : peak_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      peak_q    <= '0;
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + PEAK_DECAY_LOG2'(1);
      if (bus.clear_audio_in_memory)          peak_q <= '0;
      else if (push_ok)                       peak_q <= pk_new;
      else if ((&decay_cnt) && peak_q != '0)  peak_q <= peak_q - AUDIO_PEAK_W'(1);
    end
  end

  assign bus.peak_level = peak_q;
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: an I2S BFM (3.072 MHz BCLK, 32-bit slots) drives the
// codec pins; results are compared against hand-computed sample pairs and flags.
`timescale 1ns/1ps
module tb_i2s_adc_receiver;
  import audio_pkg::*;

  localparam int HALF_BCLK = 163;

  logic clock    = 1'b0;
  logic resetn   = 1'b0;
  logic adcdat   = 1'b0;
  logic bclk     = 1'b0;
  logic adclrck  = 1'b1;
  logic lrck_now = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  i2s_adc_receiver_if bus ();

  i2s_adc_receiver dut (
    .clock       (clock),
    .resetn      (resetn),
    .AUD_ADCDAT  (adcdat),
    .AUD_BCLK    (bclk),
    .AUD_ADCLRCK (adclrck),
    .bus         (bus)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [23:0] left_val(input int i);
    return 24'h100000 + 24'(i);
  endfunction

  function automatic logic [23:0] right_val(input int i);
    return 24'hF00000 + 24'(i);
  endfunction

  task automatic bit_period(input logic lr, input logic d);
    bclk    = 1'b0;
    adclrck = lr;
    adcdat  = d;
    #HALF_BCLK;
    bclk     = 1'b1;
    lrck_now = lr;
    #HALF_BCLK;
  endtask

  // One slot: the delay bit on an LRCK change, then MSB-first data padded with ones.
  task automatic send_slot(input logic ch, input logic [23:0] w, input int slot_bits);
    if (lrck_now != ch) bit_period(ch, 1'b1);
    for (int i = 1; i < slot_bits; i++)
      bit_period(ch, (i <= 24) ? w[24-i] : 1'b1);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot_bits);
    send_slot(1'b0, l, slot_bits);
    send_slot(1'b1, r, slot_bits);
  endtask

  task automatic flush_frame();
    if (lrck_now) bit_period(1'b0, 1'b1);
    @(negedge clock);
  endtask

  task automatic lead_in();
    send_slot(1'b1, 24'h5A5A5A, 32);
  endtask

  task automatic pop_one();
    @(negedge clock) bus.read_audio_in = 1'b1;
    @(negedge clock) bus.read_audio_in = 1'b0;
  endtask

  task automatic apply_reset();
    resetn   = 1'b0;
    bclk     = 1'b0;
    adclrck  = 1'b1;
    adcdat   = 1'b0;
    lrck_now = 1'b1;
    bus.read_audio_in         = 1'b0;
    bus.clear_audio_in_memory = 1'b0;
    repeat (4) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #40_000_000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    apply_reset();
    check("reset_available", 32'(bus.audio_in_available), 32'd0);
    check("reset_overflow",  32'(bus.overflow),           32'd0);
    check("reset_left",      bus.left_channel_audio_in,   32'd0);
    check("reset_right",     bus.right_channel_audio_in,  32'd0);

    // Basic pair after a partial sync slot.
    lead_in();
    send_frame(24'h123456, 24'hFEDCBA, 32);
    flush_frame();
    check("t1_available", 32'(bus.audio_in_available), 32'd1);
    check("t1_left",      bus.left_channel_audio_in,   32'h00123456);
    check("t1_right",     bus.right_channel_audio_in,  32'hFFFEDCBA);
    pop_one();
    check("t1_pop_available", 32'(bus.audio_in_available), 32'd0);
    check("t1_hold_left",     bus.left_channel_audio_in,   32'h00123456);
    check("t1_hold_right",    bus.right_channel_audio_in,  32'hFFFEDCBA);
    pop_one();
    check("t1_empty_pop", 32'(bus.audio_in_available), 32'd0);

    // Reset in the middle of a right word.
    apply_reset();
    lead_in();
    send_slot(1'b0, 24'h111111, 32);
    bit_period(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) bit_period(1'b1, i[0]);
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 21; i++) bit_period(1'b1, ~i[0]);
    send_slot(1'b0, 24'hABCDEF, 32);
    @(negedge clock);
    check("t2_partial_dropped", 32'(bus.audio_in_available), 32'd0);
    send_slot(1'b1, 24'h654321, 32);
    flush_frame();
    check("t2_available", 32'(bus.audio_in_available), 32'd1);
    check("t2_left",      bus.left_channel_audio_in,   32'hFFABCDEF);
    check("t2_right",     bus.right_channel_audio_in,  32'h00654321);

    // Nine pairs with no reads, then flush.
    apply_reset();
    lead_in();
    for (int i = 1; i <= 9; i++) send_frame(left_val(i), right_val(i), 32);
    flush_frame();
    check("t3_overflow",  32'(bus.overflow),           32'd1);
    check("t3_available", 32'(bus.audio_in_available), 32'd1);
    check("t3_head_left", bus.left_channel_audio_in,   32'h00100001);
    check("t3_head_right",bus.right_channel_audio_in,  32'hFFF00001);
    @(negedge clock) bus.clear_audio_in_memory = 1'b1;
    @(negedge clock) bus.clear_audio_in_memory = 1'b0;
    check("t3_clear_available", 32'(bus.audio_in_available), 32'd0);
    check("t3_clear_overflow",  32'(bus.overflow),           32'd0);
    check("t3_clear_hold_left", bus.left_channel_audio_in,   32'h00100001);

    // Full FIFO with a read on the very cycle the ninth pair is pushed.
    apply_reset();
    lead_in();
    for (int i = 1; i <= 8; i++) send_frame(left_val(i), right_val(i), 32);
    flush_frame();
    check("t4_full_no_overflow", 32'(bus.overflow), 32'd0);
    send_frame(left_val(9), right_val(9), 32);
    bclk    = 1'b0;
    adclrck = 1'b0;
    adcdat  = 1'b1;
    #HALF_BCLK;
    @(posedge clock);
    #1 bclk = 1'b1;
    lrck_now = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 bus.read_audio_in = 1'b1;
    @(posedge clock);
    #1 bus.read_audio_in = 1'b0;
    #HALF_BCLK;
    @(negedge clock);
    check("t4_overflow", 32'(bus.overflow), 32'd0);
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("t4_left_%0d", k), bus.left_channel_audio_in, {8'h00, left_val(k)});
      pop_one();
    end
    check("t4_drained", 32'(bus.audio_in_available), 32'd0);
    check("t4_last_right", bus.right_channel_audio_in, 32'hFFF00009);

    // Short 16-bit slots are dropped silently; a normal frame afterwards goes through.
    apply_reset();
    lead_in();
    send_frame(24'h0F0F0F, 24'h0F0F0F, 16);
    flush_frame();
    check("t5_short_available", 32'(bus.audio_in_available), 32'd0);
    check("t5_short_overflow",  32'(bus.overflow),           32'd0);
    send_frame(24'h7FFFFF, 24'h800000, 32);
    flush_frame();
    check("t5_available", 32'(bus.audio_in_available), 32'd1);
    check("t5_left",      bus.left_channel_audio_in,   32'h007FFFFF);
    check("t5_right",     bus.right_channel_audio_in,  32'hFF800000);

`ifdef ADC_PEAK_EN
    apply_reset();
    lead_in();
    send_frame(24'h800000, 24'h000000, 32);
    flush_frame();
    check("t6_peak", 32'(bus.peak_level), 32'h7F);
    repeat (1 << 20) @(posedge clock);
    @(negedge clock);
    check("t6_peak_decay", 32'(bus.peak_level), 32'h7E);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
